// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg
// Shared definitions for the multiply sequencer and the A/B/C control datapath:
// opcode width, the opcode values the sequencer drives, the sequencer state
// encoding (4-bit binary, ST_IDLE = 0), and a helper that maps a state to its opcode.
// No ports (package).
package mul_sequencer_pkg;

   localparam int OPCODE_W = 12;

   localparam logic [OPCODE_W-1:0] OP_IDLE   = 12'b000000001001;
   localparam logic [OPCODE_W-1:0] OP_LD_X   = 12'b000000001011;
   localparam logic [OPCODE_W-1:0] OP_LD_Y   = 12'b000000001100;
   localparam logic [OPCODE_W-1:0] OP_AND0   = 12'b001000000101;
   localparam logic [OPCODE_W-1:0] OP_SHL_B  = 12'b001000010011;
   localparam logic [OPCODE_W-1:0] OP_SHR_C  = 12'b000000101010;
   localparam logic [OPCODE_W-1:0] OP_NEG_LD = 12'b100001001011;
   localparam logic [OPCODE_W-1:0] OP_NEG    = 12'b001000011000;
   localparam logic [OPCODE_W-1:0] OP_AO_A   = 12'b100000001001;
   localparam logic [OPCODE_W-1:0] OP_BO_B   = 12'b100001001011;
   localparam logic [OPCODE_W-1:0] OP_AND_CO = 12'b001110000101;
   localparam logic [OPCODE_W-1:0] OP_AO_C   = 12'b010000101100;
   localparam logic [OPCODE_W-1:0] OP_ADD    = 12'b000000000000;
   localparam logic [OPCODE_W-1:0] OP_CO_C   = 12'b010010001100;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_LD_X   = 4'd1,
      ST_LD_Y   = 4'd2,
      ST_AND0   = 4'd3,
      ST_SHL_B  = 4'd4,
      ST_SHR_C  = 4'd5,
      ST_NEG_LD = 4'd6,
      ST_NEG    = 4'd7,
      ST_AO_A   = 4'd8,
      ST_BO_B   = 4'd9,
      ST_AND_CO = 4'd10,
      ST_AO_C   = 4'd11,
      ST_ADD    = 4'd12,
      ST_CO_C   = 4'd13,
      ST_DONE   = 4'd14
   } state_t;

   // IDLE and DONE both present the idle opcode to the datapath.
   function automatic logic [OPCODE_W-1:0] state_opcode(input state_t st);
      logic [OPCODE_W-1:0] op;
      op = OP_IDLE;
      case (st)
         ST_LD_X:   op = OP_LD_X;
         ST_LD_Y:   op = OP_LD_Y;
         ST_AND0:   op = OP_AND0;
         ST_SHL_B:  op = OP_SHL_B;
         ST_SHR_C:  op = OP_SHR_C;
         ST_NEG_LD: op = OP_NEG_LD;
         ST_NEG:    op = OP_NEG;
         ST_AO_A:   op = OP_AO_A;
         ST_BO_B:   op = OP_BO_B;
         ST_AND_CO: op = OP_AND_CO;
         ST_AO_C:   op = OP_AO_C;
         ST_ADD:    op = OP_ADD;
         ST_CO_C:   op = OP_CO_C;
         default:   op = OP_IDLE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mul_sequencer_step_timer.sv
// step_timer
// Counts how long the current sequencer step has been held and flags its final cycle.
// Ports:
//   clk       in  rising-edge clock
//   rst_n     in  asynchronous active-low reset
//   clear     in  restart the count (state is changing, or sequencer is idle)
//   step_last out high on the last cycle of a HOLD-cycle step (hold_cnt == HOLD-1)
module step_timer #(
   parameter int HOLD = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic step_last
);

   localparam int CW = $clog2(HOLD);

   logic [CW-1:0] hold_cnt;

   assign step_last = (hold_cnt == CW'(HOLD - 1));

   // Hold counter: restarts whenever the owning FSM changes state, so every
   // step starts from zero regardless of how the previous one ended.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if (clear || step_last) begin
         hold_cnt <= '0;
      end else begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer
// Drives the shift-and-add signed multiply program onto the control datapath's
// opcode bus: load X/Y, then per multiplier bit SHL_B .. CO_C, with a two-step
// negate of B inserted when the final shifted multiplier bit is negative.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a sequence (only honoured in IDLE)
//   abort  in   synchronous cancel back to IDLE, no done pulse
//   c_msb  in   sign of the shifted multiplier (control Cout[15])
//   opcode out  registered opcode to the datapath
//   busy   out  high from the first LD_X cycle to the last CO_C cycle
//   done   out  one-cycle pulse (the DONE cycle)
//   iter   out  current loop iteration, 0 outside the loop
module mul_sequencer #(
   parameter int NBITS = 5,
   parameter int HOLD  = 4,
   parameter int OPW   = 12
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           abort,
   input  logic           c_msb,
   output logic [OPW-1:0] opcode,
   output logic           busy,
   output logic           done,
   output logic [3:0]     iter
);

   import mul_sequencer_pkg::*;

   state_t         state;
   state_t         state_next;
   logic [3:0]     iter_next;
   logic [OPW-1:0] opcode_next;
   logic           busy_next;
   logic           done_next;
   logic           step_last;
   logic           last_iter;
   logic           timer_clear;

   // Iteration limit is an explicit compare, so the counter never relies on wrap.
   assign last_iter   = (iter == 4'(NBITS - 1));
   assign timer_clear = (state_next != state) || (state == ST_IDLE);

   step_timer #(.HOLD(HOLD)) u_step_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (timer_clear),
      .step_last (step_last)
   );

   // Next-state, next-iteration and next-output decode. Outputs are computed
   // from the next state so that opcode/busy/done change on the same edge as
   // the state register.
   always_comb begin
      state_next = state;
      iter_next  = iter;
      if (abort) begin
         state_next = ST_IDLE;
         iter_next  = 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state_next = ST_LD_X;
               end
            end
            ST_DONE: state_next = ST_IDLE;
            default: begin
               if (step_last) begin
                  case (state)
                     ST_LD_X:   state_next = ST_LD_Y;
                     ST_LD_Y:   state_next = ST_AND0;
                     ST_AND0:   state_next = ST_SHL_B;
                     ST_SHL_B:  state_next = ST_SHR_C;
                     // Only the final multiplier bit is a sign bit worth correcting.
                     ST_SHR_C:  state_next = (c_msb && last_iter) ? ST_NEG_LD : ST_AO_A;
                     ST_NEG_LD: state_next = ST_NEG;
                     ST_NEG:    state_next = ST_AO_A;
                     ST_AO_A:   state_next = ST_BO_B;
                     ST_BO_B:   state_next = ST_AND_CO;
                     ST_AND_CO: state_next = ST_AO_C;
                     ST_AO_C:   state_next = ST_ADD;
                     ST_ADD:    state_next = ST_CO_C;
                     ST_CO_C: begin
                        if (last_iter) begin
                           state_next = ST_DONE;
                           iter_next  = 4'd0;
                        end else begin
                           state_next = ST_SHL_B;
                           iter_next  = iter + 4'd1;
                        end
                     end
                     default: begin
                        state_next = ST_IDLE;
                        iter_next  = 4'd0;
                     end
                  endcase
               end
            end
         endcase
      end
      opcode_next = OPW'(state_opcode(state_next));
      busy_next   = (state_next != ST_IDLE) && (state_next != ST_DONE);
      done_next   = (state_next == ST_DONE);
   end

   // State and registered outputs; reset forces the idle picture immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         iter   <= 4'd0;
         opcode <= OPW'(OP_IDLE);
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_next;
         iter   <= iter_next;
         opcode <= opcode_next;
         busy   <= busy_next;
         done   <= done_next;
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer
// Two sequencers share one set of inputs: lane 0 (NBITS=5, HOLD=4) and lane 1
// (NBITS=1, HOLD=2). Each lane has a reference model that holds the expected
// per-cycle output stream as a queue built from the program listing, and a
// compare process that checks every cycle on the falling edge.
`timescale 1ns/1ps
module tb_mul_sequencer;

   localparam logic [11:0] E_IDLE   = 12'b000000001001;
   localparam logic [11:0] E_LD_X   = 12'b000000001011;
   localparam logic [11:0] E_LD_Y   = 12'b000000001100;
   localparam logic [11:0] E_AND0   = 12'b001000000101;
   localparam logic [11:0] E_SHL_B  = 12'b001000010011;
   localparam logic [11:0] E_SHR_C  = 12'b000000101010;
   localparam logic [11:0] E_NEG_LD = 12'b100001001011;
   localparam logic [11:0] E_NEG    = 12'b001000011000;
   localparam logic [11:0] E_AO_A   = 12'b100000001001;
   localparam logic [11:0] E_BO_B   = 12'b100001001011;
   localparam logic [11:0] E_AND_CO = 12'b001110000101;
   localparam logic [11:0] E_AO_C   = 12'b010000101100;
   localparam logic [11:0] E_ADD    = 12'b000000000000;
   localparam logic [11:0] E_CO_C   = 12'b010010001100;

   typedef struct packed {
      logic [11:0] op;
      logic        busy;
      logic        done;
      logic [3:0]  iter;
      logic        neg_pt;
   } exp_t;

   logic clk;
   logic rst_n;
   logic start;
   logic abort;
   logic c_msb;

   logic [1:0][11:0] opcode_w;
   logic [1:0]       busy_w;
   logic [1:0]       done_w;
   logic [1:0][3:0]  iter_w;

   int tests_run;
   int tests_failed;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [11:0] op, input logic b, input logic d,
                               input int it, input logic np);
      exp_t r;
      r.op = op; r.busy = b; r.done = d; r.iter = 4'(it); r.neg_pt = np;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int NB = (g == 0) ? 5 : 1;
      localparam int HD = (g == 0) ? 4 : 2;

      mul_sequencer #(.NBITS(NB), .HOLD(HD), .OPW(12)) dut (
         .clk    (clk),
         .rst_n  (rst_n),
         .start  (start),
         .abort  (abort),
         .c_msb  (c_msb),
         .opcode (opcode_w[g]),
         .busy   (busy_w[g]),
         .done   (done_w[g]),
         .iter   (iter_w[g])
      );

      exp_t q[$];
      exp_t cur;
      exp_t nxt;

      task automatic push_step(input logic [11:0] op, input int it, input logic mark_last);
         for (int h = 0; h < HD; h++) begin
            q.push_back(mk(op, 1'b1, 1'b0, it, mark_last && (h == HD - 1)));
         end
      endtask

      // Whole program as a flat list of cycles; the negate pair is spliced in later.
      task automatic build_program();
         q.delete();
         push_step(E_LD_X, 0, 1'b0);
         push_step(E_LD_Y, 0, 1'b0);
         push_step(E_AND0, 0, 1'b0);
         for (int i = 0; i < NB; i++) begin
            push_step(E_SHL_B,  i, 1'b0);
            push_step(E_SHR_C,  i, i == NB - 1);
            push_step(E_AO_A,   i, 1'b0);
            push_step(E_BO_B,   i, 1'b0);
            push_step(E_AND_CO, i, 1'b0);
            push_step(E_AO_C,   i, 1'b0);
            push_step(E_ADD,    i, 1'b0);
            push_step(E_CO_C,   i, 1'b0);
         end
         q.push_back(mk(E_IDLE, 1'b0, 1'b1, 0, 1'b0));
      endtask

      task automatic insert_negate();
         for (int h = 0; h < HD; h++) q.push_front(mk(E_NEG, 1'b1, 1'b0, NB - 1, 1'b0));
         for (int h = 0; h < HD; h++) q.push_front(mk(E_NEG_LD, 1'b1, 1'b0, NB - 1, 1'b0));
      endtask

      initial cur = mk(E_IDLE, 1'b0, 1'b0, 0, 1'b0);

      always @(negedge clk) begin
         if (!rst_n) begin
            q.delete();
            cur = mk(E_IDLE, 1'b0, 1'b0, 0, 1'b0);
         end
         checkOutput($sformatf("lane%0d opcode", g), 32'(opcode_w[g]), 32'(cur.op));
         checkOutput($sformatf("lane%0d busy", g),   32'(busy_w[g]),   32'(cur.busy));
         checkOutput($sformatf("lane%0d done", g),   32'(done_w[g]),   32'(cur.done));
         checkOutput($sformatf("lane%0d iter", g),   32'(iter_w[g]),   32'(cur.iter));
         if (rst_n) begin
            if (abort) begin
               q.delete();
               nxt = mk(E_IDLE, 1'b0, 1'b0, 0, 1'b0);
            end else if (q.size() == 0) begin
               if (start && !cur.done) begin
                  build_program();
                  nxt = q.pop_front();
               end else begin
                  nxt = mk(E_IDLE, 1'b0, 1'b0, 0, 1'b0);
               end
            end else begin
               if (cur.neg_pt && c_msb) insert_negate();
               nxt = q.pop_front();
            end
            cur = nxt;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic a, input logic c);
      start = s;
      abort = a;
      c_msb = c;
   endtask

   // Starts one sequence and measures cycles from the start-sampling edge to
   // each lane's done pulse. An extra start pulse can be injected mid-run.
   task automatic run_sequence(input logic cm, input int pulse_at,
                               output int lat0, output int lat1);
      int n;
      applyStimulus(1'b1, 1'b0, cm);
      tick();
      n = 1;
      lat0 = 0;
      lat1 = 0;
      applyStimulus(1'b0, 1'b0, cm);
      checkOutput("first opcode LD_X", 32'(opcode_w[0]), 32'(E_LD_X));
      while (lat0 == 0 && n < 400) begin
         start = (n == pulse_at);
         tick();
         n++;
         if (done_w[1] && lat1 == 0) lat1 = n;
         if (done_w[0]) lat0 = n;
      end
      start = 1'b0;
      tick();
   endtask

   task automatic count_done(input int cycles, output int cnt);
      cnt = 0;
      for (int k = 0; k < cycles; k++) begin
         tick();
         if (done_w[0]) cnt++;
      end
   endtask

   initial begin
      int lat0, lat1, cnt, n;
      tests_run    = 0;
      tests_failed = 0;
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      checkOutput("reset opcode", 32'(opcode_w[0]), 32'(12'b000000001001));
      checkOutput("reset busy",   32'(busy_w[0]),   32'd0);
      checkOutput("reset iter",   32'(iter_w[0]),   32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      run_sequence(1'b0, 0, lat0, lat1);
      checkOutput("latency plain lane0", lat0, 32'd173);
      checkOutput("latency plain lane1", lat1, 32'd23);

      run_sequence(1'b1, 0, lat0, lat1);
      checkOutput("latency negate lane0", lat0, 32'd181);
      checkOutput("latency negate lane1", lat1, 32'd27);

      run_sequence(1'b0, 50, lat0, lat1);
      checkOutput("latency start-while-busy", lat0, 32'd173);

      // Abort 60 cycles in, then make sure no done pulse follows.
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (59) tick();
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("abort opcode", 32'(opcode_w[0]), 32'(E_IDLE));
      checkOutput("abort busy",   32'(busy_w[0]),   32'd0);
      checkOutput("abort iter",   32'(iter_w[0]),   32'd0);
      count_done(200, cnt);
      checkOutput("abort no done", cnt, 32'd0);
      run_sequence(1'b0, 0, lat0, lat1);
      checkOutput("latency after abort", lat0, 32'd173);

      // Start held high: exactly one sequence per IDLE visit.
      applyStimulus(1'b1, 1'b0, 1'b0);
      count_done(348, cnt);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("start held done count", cnt, 32'd2);
      count_done(200, cnt);
      checkOutput("start released done count", cnt, 32'd0);

      // Asynchronous reset in the middle of iteration 2.
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0);
      n = 0;
      while (iter_w[0] != 4'd2 && n < 400) begin
         tick();
         n++;
      end
      checkOutput("reached iter 2", 32'(iter_w[0]), 32'd2);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset opcode", 32'(opcode_w[0]), 32'(12'b000000001001));
      checkOutput("async reset busy",   32'(busy_w[0]),   32'd0);
      checkOutput("async reset done",   32'(done_w[0]),   32'd0);
      checkOutput("async reset iter",   32'(iter_w[0]),   32'd0);
      tick();
      rst_n = 1'b1;
      count_done(200, cnt);
      checkOutput("no done after reset", cnt, 32'd0);

      // Randomized traffic, checked cycle by cycle by the lane models.
      for (int k = 0; k < 3000; k++) begin
         applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0,
                       1'($urandom_range(0, 1)));
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (250) tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
